data_ram_arbiter: RTL and testbench
===================================

// Module: data_ram_arbiter
// PURPOSE
//   N-port arbiter sharing one single-port synchronous data RAM (dataMem) between the core
//   LSU (port 0) and auxiliary masters (loader, DMA, debug). All ports use req/gnt/rvalid.
//   Port 0 has priority when CORE_PRIO=1. Other ports share round-robin, with an aging counter
//   so a starved port eventually preempts port 0. Replaces the fixed 2-port RAM mux on the data side.
// PARAMETERS
//   NPORTS      4   number of requester ports (1..8)
//   ADDR_WIDTH  10  word address width
//   DATA_WIDTH  32  data width; byte-enable width BE_W = DATA_WIDTH/8
//   CORE_PRIO   1   1: port 0 fixed-priority over round-robin group; 0: all ports round-robin
//   MAX_WAIT    15  wait cycles after which a requesting port is "starved"; counter width $clog2(MAX_WAIT+1)
// PORTS
//   clk            in   1                  clock, rising edge
//   rst_n          in   1                  reset, asynchronous, active-low
//   port_req_i     in   NPORTS             per-port request, held until gnt
//   port_gnt_o     out  NPORTS             per-port grant, combinational, one-hot or zero
//   port_rvalid_o  out  NPORTS             per-port response valid, 1 cycle after gnt
//   port_addr_i    in   NPORTS*ADDR_WIDTH  flattened word addresses, port i at [i*AW +: AW]
//   port_we_i      in   NPORTS             1 = write
//   port_be_i      in   NPORTS*BE_W        flattened byte enables
//   port_wdata_i   in   NPORTS*DATA_WIDTH  flattened write data
//   port_rdata_o   out  DATA_WIDTH         read data broadcast to all ports; qualify with rvalid
//   ram_en_o       out  1                  RAM access this cycle (= |port_gnt_o)
//   ram_addr_o     out  ADDR_WIDTH         address of granted port (0 when idle)
//   ram_we_o       out  1                  we of granted port (0 when idle)
//   ram_be_o       out  BE_W               be of granted port (0 when idle)
//   ram_wdata_o    out  DATA_WIDTH         wdata of granted port
//   ram_rdata_i    in   DATA_WIDTH         RAM read data, valid 1 cycle after ram_en_o
//   starve_o       out  NPORTS             per-port wait counter == MAX_WAIT (debug/perf)
// BEHAVIOUR
//   Reset (rst_n=0, async)
//     rr_ptr=1 (0 if CORE_PRIO=0), rvalid_q=0, all wait counters=0.
//     port_gnt_o/port_rvalid_o/starve_o=0; ram_* outputs=0.
//   Grant, combinational each cycle; at most one port granted.
//     1) starved set = req & (wait==MAX_WAIT): grant the first port at or after rr_ptr, cyclic.
//     2) else if CORE_PRIO and req[0]: grant port 0.
//     3) else grant the first requesting port at or after rr_ptr, cyclic, skipping port 0 when CORE_PRIO.
//   Round-robin pointer
//     On any grant to port k in the round-robin group: rr_ptr <= next group index after k, wraps.
//     A port-0 priority grant does not move rr_ptr.
//   Response
//     rvalid_q <= port_gnt_o, so port_rvalid_o[k]=1 exactly one cycle after gnt[k], for reads and writes.
//     port_rdata_o = ram_rdata_i, unregistered. Back-to-back grants are allowed, so throughput is 1 access/cycle.
//   Wait counters, per port
//     req & !gnt: increment, saturate at MAX_WAIT.
//     gnt or !req: clear to 0.
//     Dropping req before gnt is legal; the counter clears.
//   Boundaries
//     NPORTS=1: gnt=req, no pointer.
//     All ports starved at once: round-robin order among them.
//     Simultaneous gnt to port k and rvalid to port j: independent.
//     Reset mid-access: pending rvalid is lost; masters must also be reset.
//   Ordering
//     Accesses are performed in grant order.
//     A write granted at cycle t is visible to a read granted at t+1.
// STRUCTURE
//   Shared package/defines (data_ram_arb_defs.vh): BE_W macro, CLOG2 helper, port index of core (0).
//   Sub-module rr_pick: given req vector and start pointer, returns one-hot of first set bit at/after
//     pointer, cyclic. Used twice: once for the starved set, once for normal requests.
//   Top level holds rr_ptr, rvalid_q, wait counters, and the output muxes (AND-OR on one-hot gnt).
// TESTING
//   Single read, NPORTS=4: port2 req, addr=0x010, RAM word 0xDEADBEEF
//     -> gnt[2] same cycle, rvalid[2] next cycle, port_rdata_o=0xDEADBEEF.
//   Priority: port0 and port1 both req every cycle, CORE_PRIO=1, MAX_WAIT=15
//     -> port0 granted for 15 cycles; port1 granted on cycle 16 (starve_o[1]=1 that cycle); then port0 again.
//   Round-robin: ports 1,2,3 req continuously, port0 idle
//     -> grant order 1,2,3,1,2,3; ram_en_o=1 every cycle, no gaps.
//   Write then read: port1 write addr 0x005 be=4'b0011 wdata=0x0000ABCD over 0x11223344, then port3 read 0x005
//     -> port3 reads 0x1122ABCD.
//   Abandoned request: port2 req for 3 cycles without gnt, then drops
//     -> wait[2] returns to 0, no rvalid[2].
//   Async reset asserted mid-stream
//     -> outputs 0 immediately without clk; after release, rr_ptr=1 and first grant to port1 over port2.

Source files
------------

// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter.
//   CORE_PORT : index of the core LSU port, the one that can take fixed priority.
//   be_width  : byte-enable width for a given data width.
//   idx_width : width of a port index / pointer (at least 1 bit, also for one port).
//   wait_width: width of a wait counter that must hold 0..max_wait.
package data_ram_arbiter_pkg;

    localparam int CORE_PORT = 0;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wait_width(input int max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_pick.sv
// Cyclic first-one picker.
//   req   : candidate vector
//   start : index where the search begins
//   pick  : one-hot of the first set bit of req at or after start, wrapping
//           past the top back to bit 0; zero when req is zero.
// The vector is rotated so that start lands on bit 0, the lowest set bit is
// isolated with x & -x, and the result is rotated back.
module data_ram_arbiter_rr_pick
    import data_ram_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  pick
);

    logic [N-1:0]   req_rot;
    logic [N-1:0]   pick_rot;
    logic [2*N-1:0] pick_dbl;

    assign req_rot  = N'({req, req} >> start);
    assign pick_rot = req_rot & (~req_rot + N'(1));
    assign pick_dbl = {{N{1'b0}}, pick_rot} << start;
    assign pick     = pick_dbl[N-1:0] | pick_dbl[2*N-1:N];

endmodule

// File: rtl/data_ram_arbiter.sv
// N-port arbiter in front of one single-port synchronous data RAM.
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   port_req_i       : per-port request, held until granted (may be dropped)
//   port_gnt_o       : per-port grant, combinational, one-hot or zero
//   port_rvalid_o    : per-port response valid, one cycle after the grant
//   port_addr_i/we_i/be_i/wdata_i : flattened per-port access fields
//   port_rdata_o     : RAM read data broadcast to all ports (qualify with rvalid)
//   ram_*_o          : access of the granted port toward the RAM (0 when idle)
//   ram_rdata_i      : RAM read data, one cycle after ram_en_o
//   starve_o         : per-port wait counter has reached MAX_WAIT
// Grant order: starved requesters (round-robin) > core port (when CORE_PRIO)
// > round-robin group. The group is ports 1..N-1 with CORE_PRIO, else all.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CORE_PRIO  = 1,
    parameter int MAX_WAIT   = 15,
    localparam int BE_W      = be_width(DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NPORTS-1:0]            port_req_i,
    output logic [NPORTS-1:0]            port_gnt_o,
    output logic [NPORTS-1:0]            port_rvalid_o,
    input  logic [NPORTS*ADDR_WIDTH-1:0] port_addr_i,
    input  logic [NPORTS-1:0]            port_we_i,
    input  logic [NPORTS*BE_W-1:0]       port_be_i,
    input  logic [NPORTS*DATA_WIDTH-1:0] port_wdata_i,
    output logic [DATA_WIDTH-1:0]        port_rdata_o,
    output logic                         ram_en_o,
    output logic [ADDR_WIDTH-1:0]        ram_addr_o,
    output logic                         ram_we_o,
    output logic [BE_W-1:0]              ram_be_o,
    output logic [DATA_WIDTH-1:0]        ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]        ram_rdata_i,
    output logic [NPORTS-1:0]            starve_o
);

    localparam int PW = idx_width(NPORTS);
    localparam int WW = wait_width(MAX_WAIT);

    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    // Bit set for the port that takes fixed priority; empty when CORE_PRIO=0.
    localparam logic [NPORTS-1:0] PRIO_MASK =
        (CORE_PRIO != 0) ? (NPORTS'(1) << CORE_PORT) : {NPORTS{1'b0}};
    localparam logic [PW-1:0] RR_FIRST = PW'(((CORE_PRIO != 0) && (NPORTS > 1)) ? 1 : 0);
    localparam logic [PW-1:0] LAST_IDX = PW'(NPORTS - 1);

    logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [NPORTS-1:0] rvalid_reg;
    logic [NPORTS-1:0] req_starved, pick_starved;
    logic [NPORTS-1:0] req_rr, pick_rr;
    logic [NPORTS-1:0] gnt;
    logic [PW-1:0]     gnt_idx;

    // ---------------------------------------------------------------- wait counters
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_wait
        logic [WW-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (port_req_i[gi] && !gnt[gi]) begin
                if (cnt_reg != WAIT_MAX) begin
                    cnt_reg <= cnt_reg + WW'(1);
                end
            end else begin
                // Granted or no longer requesting (an abandoned request is legal).
                cnt_reg <= '0;
            end
        end

        assign starve_o[gi]    = (cnt_reg == WAIT_MAX);
        assign req_starved[gi] = port_req_i[gi] && (cnt_reg == WAIT_MAX);
    end

    // ---------------------------------------------------------------- grant
    assign req_rr = port_req_i & ~PRIO_MASK;

    data_ram_arbiter_rr_pick #(.N(NPORTS)) u_pick_starved (
        .req   (req_starved),
        .start (rr_ptr_reg),
        .pick  (pick_starved)
    );

    data_ram_arbiter_rr_pick #(.N(NPORTS)) u_pick_rr (
        .req   (req_rr),
        .start (rr_ptr_reg),
        .pick  (pick_rr)
    );

    // Gated by rst_n so the RAM side goes quiet as soon as reset asserts,
    // even while masters still hold their requests.
    always_comb begin
        gnt = '0;
        if (!rst_n) begin
            gnt = '0;
        end else if (|req_starved) begin
            gnt = pick_starved;
        end else if (|(port_req_i & PRIO_MASK)) begin
            gnt = PRIO_MASK;
        end else begin
            gnt = pick_rr;
        end
    end

    assign port_gnt_o = gnt;

    // ---------------------------------------------------------------- round-robin pointer
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

    // Only grants inside the round-robin group advance the pointer; a grant
    // to the priority port (even a starvation grant) leaves it in place.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (|(gnt & ~PRIO_MASK)) begin
            rr_ptr_next = (gnt_idx == LAST_IDX) ? RR_FIRST : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= RR_FIRST;
            rvalid_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            rvalid_reg <= gnt;
        end
    end

    assign port_rvalid_o = rvalid_reg;
    assign port_rdata_o  = ram_rdata_i;

    // ---------------------------------------------------------------- RAM-side AND-OR mux
    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        for (int i = 0; i < NPORTS; i++) begin
            ram_addr_o  = ram_addr_o  | (port_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{gnt[i]}});
            ram_we_o    = ram_we_o    | (port_we_i[i] & gnt[i]);
            ram_be_o    = ram_be_o    | (port_be_i[i*BE_W +: BE_W] & {BE_W{gnt[i]}});
            ram_wdata_o = ram_wdata_o | (port_wdata_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt[i]}});
        end
    end

    assign ram_en_o = |gnt;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Testbench for data_ram_arbiter (NPORTS=4, CORE_PRIO=1, MAX_WAIT=15).
// A bench-side RAM answers the DUT's RAM port. A behavioural model (integer
// pointer, integer wait counts, word array) predicts every output each cycle
// on the falling edge; directed phases add literal expectations.
module tb_data_ram_arbiter;

    localparam int N    = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXW = 15;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]  req_v = '0;
    logic [N-1:0]  we_v  = '0;
    logic [AW-1:0] addr_a  [N];
    logic [BW-1:0] be_a    [N];
    logic [DW-1:0] wdata_a [N];

    logic [N*AW-1:0] port_addr;
    logic [N*BW-1:0] port_be;
    logic [N*DW-1:0] port_wdata;

    logic [N-1:0]  port_gnt, port_rvalid, starve;
    logic [DW-1:0] port_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_be;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always_comb begin
        port_addr  = '0;
        port_be    = '0;
        port_wdata = '0;
        for (int i = 0; i < N; i++) begin
            port_addr[i*AW +: AW]  = addr_a[i];
            port_be[i*BW +: BW]    = be_a[i];
            port_wdata[i*DW +: DW] = wdata_a[i];
        end
    end

    data_ram_arbiter #(
        .NPORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CORE_PRIO(1), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .port_req_i(req_v), .port_gnt_o(port_gnt), .port_rvalid_o(port_rvalid),
        .port_addr_i(port_addr), .port_we_i(we_v), .port_be_i(port_be),
        .port_wdata_i(port_wdata), .port_rdata_o(port_rdata),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .starve_o(starve)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 16'h010) return 32'hDEADBEEF;
        if (i == 5)       return 32'h11223344;
        return 32'hA500_0000 | DW'(i);
    endfunction

    // ---------------------------------------------------------------- bench RAM
    bit ram_ready;
    logic [DW-1:0] ram [DEPTH];

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < BW; b++)
                    if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram[ram_addr];
            end
        end
    end

    // ---------------------------------------------------------------- checking
    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- behavioural model
    int            m_rr = 1;
    int            m_wait [N];
    logic [N-1:0]  m_prev = '0;
    bit            m_prev_rd;
    logic [DW-1:0] m_exp_rdata;
    logic [DW-1:0] mmem [DEPTH];

    // Which port gets the RAM this cycle, straight from the arbitration rules.
    function automatic logic [N-1:0] model_grant(input logic [N-1:0] req);
        logic [N-1:0] g;
        int k;
        g = '0;
        for (int o = 0; o < N; o++) begin
            k = (m_rr + o) % N;
            if (req[k] && m_wait[k] == MAXW) begin
                g[k] = 1'b1;
                return g;
            end
        end
        if (req[0]) begin
            g[0] = 1'b1;
            return g;
        end
        for (int o = 0; o < N; o++) begin
            k = (m_rr + o) % N;
            if (k != 0 && req[k]) begin
                g[k] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    initial begin : model
        logic [N-1:0] g;
        logic [N-1:0] exp_starve;
        int gk;
        for (int i = 0; i < DEPTH; i++) mmem[i] = init_word(i);
        for (int p = 0; p < N; p++) m_wait[p] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_gnt", port_gnt, 0);
                chk("rst_rvalid", port_rvalid, 0);
                chk("rst_ram_en", ram_en, 0);
                chk("rst_starve", starve, 0);
                m_rr = 1;
                for (int p = 0; p < N; p++) m_wait[p] = 0;
                m_prev = '0;
                m_prev_rd = 1'b0;
            end else begin
                g  = model_grant(req_v);
                gk = -1;
                for (int p = 0; p < N; p++) if (g[p]) gk = p;
                exp_starve = '0;
                for (int p = 0; p < N; p++) exp_starve[p] = (m_wait[p] == MAXW);

                chk("gnt", port_gnt, g);
                chk("ram_en", ram_en, (gk >= 0));
                chk("ram_addr", ram_addr, (gk >= 0) ? addr_a[gk] : '0);
                chk("ram_we", ram_we, (gk >= 0) ? we_v[gk] : 1'b0);
                chk("ram_be", ram_be, (gk >= 0) ? be_a[gk] : '0);
                if (gk >= 0) chk("ram_wdata", ram_wdata, wdata_a[gk]);
                chk("starve", starve, exp_starve);
                chk("rvalid", port_rvalid, m_prev);
                if (m_prev != 0 && m_prev_rd) chk("rdata", port_rdata, m_exp_rdata);

                for (int p = 0; p < N; p++) begin
                    if (req_v[p] && !g[p]) m_wait[p] = (m_wait[p] < MAXW) ? m_wait[p] + 1 : MAXW;
                    else m_wait[p] = 0;
                end
                if (gk > 0) m_rr = (gk == N - 1) ? 1 : gk + 1;
                if (gk >= 0) begin
                    if (we_v[gk]) begin
                        for (int b = 0; b < BW; b++)
                            if (be_a[gk][b]) mmem[addr_a[gk]][8*b +: 8] = wdata_a[gk][8*b +: 8];
                        m_prev_rd = 1'b0;
                        $display("[TB] t=%0t port%0d WR addr=0x%03h be=%b wdata=0x%08h",
                                 $time, gk, addr_a[gk], be_a[gk], wdata_a[gk]);
                    end else begin
                        m_exp_rdata = mmem[addr_a[gk]];
                        m_prev_rd = 1'b1;
                        $display("[TB] t=%0t port%0d RD addr=0x%03h expect=0x%08h",
                                 $time, gk, addr_a[gk], m_exp_rdata);
                    end
                end
                m_prev = g;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        req_v[p] = 1'b1;
        we_v[p] = 1'b0;
        addr_a[p] = a;
        be_a[p] = '1;
        wdata_a[p] = '0;
    endtask

    task automatic new_txn(input int p);
        req_v[p] = 1'b1;
        we_v[p] = 1'($urandom_range(0, 1));
        addr_a[p] = AW'($urandom_range(0, 15));
        be_a[p] = BW'($urandom_range(0, 15));
        wdata_a[p] = $urandom;
    endtask

    initial begin : driver
        int rr_order [6];
        logic [N-1:0] g;
        rr_order = '{1, 2, 3, 1, 2, 3};
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0;
            be_a[i] = '0;
            wdata_a[i] = '0;
        end

        // Reset state
        #3;
        chk("reset_gnt", port_gnt, 0);
        chk("reset_rvalid", port_rvalid, 0);
        chk("reset_ram_en", ram_en, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin among ports 1..3, core idle
        step();
        for (int p = 1; p < N; p++) set_rd(p, AW'(32 + p));
        for (int c = 0; c < 6; c++) begin
            settle();
            chk("rr_gnt", port_gnt, 4'b0001 << rr_order[c]);
            chk("rr_ram_en", ram_en, 1);
            step();
        end
        req_v = '0;

        // Single read from port 2
        set_rd(2, 10'h010);
        settle();
        chk("rd_gnt", port_gnt, 4'b0100);
        chk("rd_addr", ram_addr, 10'h010);
        step();
        req_v = '0;
        settle();
        chk("rd_rvalid", port_rvalid, 4'b0100);
        chk("rd_rdata", port_rdata, 32'hDEADBEEF);

        // Core priority vs. aging of port 1
        step();
        set_rd(0, 10'd1);
        set_rd(1, 10'd2);
        for (int c = 1; c <= 17; c++) begin
            settle();
            chk("prio_gnt", port_gnt, (c == 16) ? 4'b0010 : 4'b0001);
            if (c == 16) begin
                chk("prio_starve1", starve[1], 1);
                chk("prio_model_wait1", m_wait[1], 15);
            end
            step();
        end
        req_v = '0;

        // Write port 1, then read port 3 from the same word
        req_v[1] = 1'b1;
        we_v[1] = 1'b1;
        addr_a[1] = 10'h005;
        be_a[1] = 4'b0011;
        wdata_a[1] = 32'h0000ABCD;
        settle();
        chk("wr_gnt", port_gnt, 4'b0010);
        step();
        req_v = '0;
        we_v = '0;
        set_rd(3, 10'h005);
        settle();
        chk("wrrd_gnt", port_gnt, 4'b1000);
        step();
        req_v = '0;
        settle();
        chk("wrrd_rvalid", port_rvalid, 4'b1000);
        chk("wrrd_rdata", port_rdata, 32'h1122ABCD);

        // Port 2 waits behind the core for 3 cycles, then gives up
        step();
        set_rd(0, 10'd0);
        set_rd(2, 10'd7);
        for (int c = 1; c <= 3; c++) begin
            settle();
            chk("abandon_gnt", port_gnt, 4'b0001);
            chk("abandon_rvalid2", port_rvalid[2], 0);
            step();
        end
        chk("abandon_model_wait2_held", m_wait[2], 3);
        req_v = '0;
        @(negedge clk);
        #1;
        chk("abandon_model_wait2_clear", m_wait[2], 0);
        chk("abandon_rvalid2_c4", port_rvalid[2], 0);
        step();
        settle();
        chk("abandon_rvalid2_c5", port_rvalid[2], 0);

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            #1;
            g = port_gnt;
            @(posedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (req_v[p] && g[p]) begin
                    if ($urandom_range(0, 99) < 60) new_txn(p);
                    else req_v[p] = 1'b0;
                end else if (req_v[p]) begin
                    if ($urandom_range(0, 99) < 4) req_v[p] = 1'b0;
                end else if ($urandom_range(0, 99) < ((p == 0) ? 70 : 40)) begin
                    new_txn(p);
                end
            end
        end

        // Asynchronous reset in the middle of a busy cycle
        step();
        for (int p = 0; p < N; p++) new_txn(p);
        settle();
        rst_n = 1'b0;
        #1;
        chk("async_gnt", port_gnt, 0);
        chk("async_rvalid", port_rvalid, 0);
        chk("async_ram_en", ram_en, 0);
        chk("async_ram_addr", ram_addr, 0);
        chk("async_ram_we", ram_we, 0);
        chk("async_ram_be", ram_be, 0);
        chk("async_starve", starve, 0);
        step();
        req_v = '0;
        we_v = '0;
        step();
        rst_n = 1'b1;
        set_rd(1, 10'd9);
        set_rd(2, 10'd10);
        settle();
        chk("post_reset_gnt", port_gnt, 4'b0010);
        step();
        req_v = '0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
